// File: rtl/enc_bind_scheduler.sv
// rtl/enc_bind_scheduler.sv - sequences the encoding binder pack over feature groups
//
// Splits NUM_FEATURES features into groups of LANES. Per group: fetch level
// HVs, pulse the binder pack, wait BIND_LAT cycles, then offer the shifted
// HVs to the bundler with a valid/ready handshake.
//
// Ports:
//   i_clk             clock, rising edge
//   i_nrst            synchronous active-low reset
//   i_start           begin one sample (accepted in IDLE only)
//   i_abort           synchronous cancel, overrides everything but reset
//   o_busy            high in every state except IDLE
//   o_done            one-cycle pulse after the final group is accepted
//   o_lvl_req         level-HV request for the current group
//   o_lvl_addr        first feature index of the current group
//   i_lvl_gnt         level HVs present on the binder-pack inputs
//   o_start_encoding  one-cycle pulse to the binder pack
//   o_acc_valid       shifted HVs of the current group are valid
//   i_acc_ready       bundler accepts the current group
//   o_acc_group       current group index
//   o_acc_last        current group is the final one
//   o_lane_mask       bit i set when lane i carries a real feature
module enc_bind_scheduler #(
  parameter int NUM_FEATURES = 40,
  parameter int LANES        = 10,
  parameter int BIND_LAT     = 1,
  parameter int FEAT_W       = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
  parameter int GRP_W        = (((NUM_FEATURES + LANES - 1) / LANES) > 1) ?
                               $clog2((NUM_FEATURES + LANES - 1) / LANES) : 1
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_lvl_req,
  output logic [FEAT_W-1:0] o_lvl_addr,
  input  logic              i_lvl_gnt,
  output logic              o_start_encoding,
  output logic              o_acc_valid,
  input  logic              i_acc_ready,
  output logic [GRP_W-1:0]  o_acc_group,
  output logic              o_acc_last,
  output logic [LANES-1:0]  o_lane_mask
);

  localparam int NUM_GROUPS = (NUM_FEATURES + LANES - 1) / LANES;
  localparam int LAST_LANES = NUM_FEATURES - (NUM_GROUPS - 1) * LANES;
  localparam int CNT_W      = (BIND_LAT > 1) ? $clog2(BIND_LAT + 1) : 1;
  localparam logic [LANES-1:0] ALL_MASK  = {LANES{1'b1}};
  localparam logic [LANES-1:0] LAST_MASK = ALL_MASK >> (LANES - LAST_LANES);
  localparam logic [GRP_W-1:0] LAST_GRP  = GRP_W'(NUM_GROUPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_BIND,
    S_WAIT,
    S_ACC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [GRP_W-1:0] r_group;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_next_state;
  logic [GRP_W-1:0] w_next_group;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_next_last;
  logic             w_next_active;
  logic [FEAT_W-1:0] w_next_addr;

  always_comb begin
    w_next_state = r_state;
    w_next_group = r_group;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = S_FETCH;
          w_next_group = '0;
        end
      end
      S_FETCH: begin
        if (i_lvl_gnt) w_next_state = S_BIND;
      end
      S_BIND: begin
        w_next_cnt   = CNT_W'(BIND_LAT);
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        w_next_cnt = r_cnt - 1'b1;
        if (r_cnt <= CNT_W'(1)) w_next_state = S_ACC;
      end
      S_ACC: begin
        // Last group is detected before incrementing, so the index never wraps.
        if (i_acc_ready) begin
          if (r_group == LAST_GRP) begin
            w_next_state = S_DONE;
          end else begin
            w_next_group = r_group + 1'b1;
            w_next_state = S_FETCH;
          end
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (i_abort) begin
      w_next_state = S_IDLE;
      w_next_group = '0;
      w_next_cnt   = '0;
    end
  end

  // Outputs are decoded from the next state and registered, so no input
  // reaches an output without passing through a flop.
  always_comb begin
    w_next_last   = (w_next_group == LAST_GRP);
    w_next_active = (w_next_state == S_FETCH) || (w_next_state == S_BIND) ||
                    (w_next_state == S_WAIT)  || (w_next_state == S_ACC);
    w_next_addr   = FEAT_W'(int'(w_next_group) * LANES);
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state          <= S_IDLE;
      r_group          <= '0;
      r_cnt            <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_lvl_req        <= 1'b0;
      o_lvl_addr       <= '0;
      o_start_encoding <= 1'b0;
      o_acc_valid      <= 1'b0;
      o_acc_group      <= '0;
      o_acc_last       <= 1'b0;
      o_lane_mask      <= '0;
    end else begin
      r_state          <= w_next_state;
      r_group          <= w_next_group;
      r_cnt            <= w_next_cnt;
      o_busy           <= (w_next_state != S_IDLE);
      o_done           <= (w_next_state == S_DONE);
      o_lvl_req        <= (w_next_state == S_FETCH);
      o_start_encoding <= (w_next_state == S_BIND);
      o_acc_valid      <= (w_next_state == S_ACC);
      o_acc_last       <= (w_next_state == S_ACC) && w_next_last;
      o_lvl_addr       <= w_next_active ? w_next_addr : '0;
      o_acc_group      <= w_next_active ? w_next_group : '0;
      o_lane_mask      <= w_next_active ? (w_next_last ? LAST_MASK : ALL_MASK) : '0;
    end
  end

endmodule

// File: doc/enc_bind_scheduler.md
Name: enc_bind_scheduler

Overview:
Sequences the 10-lane encoding binder pack across a feature vector longer than the lane count. The block splits NUM_FEATURES features into groups of LANES. For each group it fetches the level HVs, pulses start_encoding to the binder pack, and waits the binder latency. It then hands the shifted HVs to the downstream bundler/accumulator with a valid/ready handshake. It sits between the top-level encoder FSM, the level-HV memory and the binder pack / bundler.

Parameters:
NUM_FEATURES, 40, total features per sample (>= 1)
LANES, 10, binders per pack = features per group
BIND_LAT, 1, cycles from start_encoding pulse to shifted_hv valid (>= 1)
FEAT_W, $clog2(NUM_FEATURES) (min 1), width of feature index
GRP_W, $clog2(ceil(NUM_FEATURES/LANES)) (min 1), width of group index

Ports:
clk  in  1  clock, all logic on rising edge
nrst  in  1  synchronous active-low reset
start  in  1  begin encoding one sample; ignored unless IDLE
abort  in  1  synchronous cancel; wins over every other input except nrst
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after last group accepted
lvl_req  out  1  request level HVs for lanes feat_base..feat_base+LANES-1
lvl_addr  out  FEAT_W  first feature index of current group (feat_base)
lvl_gnt  in  1  level HVs present on binder-pack inputs this cycle
start_encoding  out  1  one-cycle pulse to binder pack
acc_valid  out  1  shifted_hv of current group valid for bundler
acc_ready  in  1  bundler accepts group
acc_group  out  GRP_W  index of current group
acc_last  out  1  current group is final group
lane_mask  out  LANES  bit i = lane i carries a real feature

Behaviour:
- NUM_GROUPS = ceil(NUM_FEATURES/LANES). feat_base = group*LANES.
- States: IDLE, FETCH, BIND, WAIT, ACC, DONE.
- IDLE: all outputs 0. When start=1 (and abort=0): group<=0, go to FETCH.
- FETCH: lvl_req=1, lvl_addr=feat_base. Hold until lvl_gnt=1, then go to BIND. lvl_gnt outside FETCH is ignored.
- BIND: start_encoding=1 for exactly this cycle. Load wait counter with BIND_LAT. Go to WAIT.
- WAIT: counter decrements each cycle. After BIND_LAT WAIT cycles, go to ACC.
- ACC: acc_valid=1, acc_group=group, acc_last=(group==NUM_GROUPS-1). acc_valid, acc_group, acc_last and lane_mask are stable until acc_ready=1.
  - acc_ready=1 and not last: group++, go to FETCH.
  - acc_ready=1 and last: go to DONE.
- DONE: done=1 for one cycle, busy=1. Go to IDLE.
- lane_mask:
  - all ones for non-final groups.
  - final group: low (NUM_FEATURES - (NUM_GROUPS-1)*LANES) bits set, rest 0.
  - driven 0 in IDLE.
- lvl_addr, acc_group and lane_mask are 0 in IDLE. In FETCH/BIND/WAIT/ACC they reflect the current group.
- Handshake outputs (lvl_req, start_encoding, acc_valid, done) are registered state decodes. No combinational path from any input to any output.
- start while busy: ignored, no queuing. start in the same cycle as DONE is ignored; a new start is accepted in IDLE only.
- abort=1 in any state: next cycle IDLE, all outputs 0, no done pulse. An in-flight start_encoding is not re-issued. abort and start together in IDLE: stays IDLE.
- nrst=0 at a clock edge: state IDLE, group=0, counter=0, all outputs 0. This holds mid-operation too.
- Fastest group (lvl_gnt and acc_ready tied high) = 3+BIND_LAT cycles (FETCH, BIND, WAIT×BIND_LAT, ACC).
- Counter width covers BIND_LAT. Group increment never wraps, because last is detected before increment.

Test Plan:
1. Defaults, lvl_gnt=acc_ready=1, start pulse at cycle 0.
   - FETCH at cycle 1; acc_valid in cycles 4, 8, 12, 16 with acc_group 0..3.
   - lvl_addr 0, 10, 20, 30; acc_last only at cycle 16; done at cycle 17; busy cycles 1-17.
   - Exactly 4 start_encoding pulses.
2. NUM_FEATURES=35: lane_mask = 10'h3FF for groups 0-2 and 10'h01F for group 3; 4 groups total.
3. lvl_gnt held low 5 cycles in group 1, acc_ready low 3 cycles in group 2.
   - lvl_req held with lvl_addr=10 throughout the stall; no start_encoding during it.
   - acc_valid/acc_group=2 held through the stall; done at cycle 17+8=25.
4. BIND_LAT=3: each start_encoding is followed by exactly 3 WAIT cycles before acc_valid; done at cycle 25 with all handshakes tied high.
5. abort in ACC of group 1, with start pulsed again during the run.
   - IDLE next cycle, no done, busy=0; mid-run start has no effect.
   - A following start re-runs from group 0 with lvl_addr=0.
6. nrst low for 1 cycle during WAIT: all outputs 0 next cycle, state IDLE. Then start works normally.
